// File: rtl/sfx_arbiter.sv
// Fixed-priority sound-effect scheduler driving the single speaker pin.
// Plays one square-wave effect at a time, with preemption, retrigger and a silent gap.
module sfx_arbiter #(
    parameter int TICK_DIV  = 100000,
    parameter int HP_SHIFT  = 0,
    parameter int GAP_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       music_in,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] active_id,
    output logic [3:0] grant,
    output logic [1:0] state_dbg
);

    // Handshake: req bits are one-cycle pulses and are never back-pressured; each
    // accepted request is answered by exactly one single-cycle one-hot grant pulse.
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

    localparam logic [16:0] TICK_LAST = 17'(TICK_DIV - 1);
    localparam logic [7:0]  GAP_LOAD  = 8'(GAP_TICKS);

    function automatic logic [17:0] eff_hp(input logic [1:0] id);
        int raw;
        case (id)
            2'd0:    raw = 151684;
            2'd1:    raw = 227272;
            2'd2:    raw = 255102;
            default: raw = 95556;
        endcase
        raw = raw >> HP_SHIFT;
        if (raw < 1) raw = 1;
        return 18'(raw);
    endfunction

    function automatic logic [7:0] eff_dur(input logic [1:0] id);
        case (id)
            2'd0:    return 8'd150;
            2'd1:    return 8'd100;
            2'd2:    return 8'd120;
            default: return 8'd200;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  pend_q, pend_d;
    logic [7:0]  dur_q, dur_d;
    logic [16:0] tick_q, tick_d;
    logic [17:0] hp_q, hp_d;
    logic [1:0]  id_q, id_d;
    logic        spk_q, spk_d;
    logic [3:0]  grant_q, grant_d;

    logic [1:0]  hi_idx;
    logic [3:0]  req_masked;
    logic [17:0] hp_last;
    logic        start;
    logic        tick_wrap;

    always_comb begin
        hi_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pend_q[i]) hi_idx = 2'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        dur_d      = dur_q;
        tick_d     = tick_q;
        hp_d       = hp_q;
        id_d       = id_q;
        spk_d      = spk_q;
        grant_d    = 4'b0000;
        start      = 1'b0;
        req_masked = req;
        hp_last    = eff_hp(id_q) - 18'd1;
        tick_wrap  = (tick_q == TICK_LAST);

        // A request for the effect already playing is a retrigger, not a new pend.
        if (state_q == PLAY) req_masked[id_q] = 1'b0;

        case (state_q)
            IDLE: begin
                spk_d = music_in & ~mute;
                if (pend_q != 4'b0000) start = 1'b1;
            end
            PLAY: begin
                if (pend_q != 4'b0000 && hi_idx > id_q) begin
                    start = 1'b1;
                end else begin
                    if (hp_q == hp_last) begin
                        hp_d  = 18'd0;
                        spk_d = ~spk_q;
                    end else begin
                        hp_d = hp_q + 18'd1;
                    end
                    if (req[id_q]) begin
                        dur_d   = eff_dur(id_q);
                        tick_d  = 17'd0;
                        grant_d = 4'b0001 << id_q;
                    end else if (tick_wrap) begin
                        tick_d = 17'd0;
                        if (dur_q == 8'd1) begin
                            spk_d   = 1'b0;
                            dur_d   = GAP_LOAD;
                            state_d = (GAP_TICKS == 0) ? IDLE : GAP;
                        end else begin
                            dur_d = dur_q - 8'd1;
                        end
                    end else begin
                        tick_d = tick_q + 17'd1;
                    end
                end
            end
            GAP: begin
                spk_d = 1'b0;
                if (tick_wrap) begin
                    tick_d = 17'd0;
                    if (dur_q <= 8'd1) state_d = IDLE;
                    else dur_d = dur_q - 8'd1;
                end else begin
                    tick_d = tick_q + 17'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        pend_d = pend_q | req_masked;

        if (start) begin
            pend_d[hi_idx] = 1'b0;
            id_d           = hi_idx;
            dur_d          = eff_dur(hi_idx);
            tick_d         = 17'd0;
            hp_d           = 18'd0;
            spk_d          = 1'b0;
            grant_d        = 4'b0001 << hi_idx;
            state_d        = PLAY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            dur_q   <= 8'd0;
            tick_q  <= 17'd0;
            hp_q    <= 18'd0;
            id_q    <= 2'd0;
            spk_q   <= 1'b0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dur_q   <= dur_d;
            tick_q  <= tick_d;
            hp_q    <= hp_d;
            id_q    <= id_d;
            spk_q   <= spk_d;
            grant_q <= grant_d;
        end
    end

    assign speaker   = spk_q;
    assign busy      = (state_q == PLAY) || (state_q == GAP);
    assign active_id = id_q;
    assign grant     = grant_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter: reset, single play, priority queueing,
// preemption, retrigger, music passthrough and mid-play reset.
module tb_sfx_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       music_in;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] active_id;
  logic [3:0] grant;
  logic [1:0] state_dbg;

  int errors;
  int checks;
  int rel;

  sfx_arbiter #(
    .TICK_DIV (10),
    .HP_SHIFT (10),
    .GAP_TICKS(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .music_in (music_in),
    .mute     (mute),
    .speaker  (speaker),
    .busy     (busy),
    .active_id(active_id),
    .grant    (grant),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: everything is driven and sampled on the falling edge
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    rel += n;
  endtask

  task automatic goto_rel(input int t);
    adv(t - rel);
  endtask

  // Pulse req for one cycle; returns half a cycle after the grant edge (rel = 0).
  task automatic start_req(input logic [3:0] r);
    req = r;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    rel = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req = 4'b0000;
    music_in = 1'b0;
    mute = 1'b0;
    adv(3);
    checks++;
    if ({speaker, busy, active_id, grant, state_dbg} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got spk=%b busy=%b id=%0d grant=%b st=%0d expected all 0",
               speaker, busy, active_id, grant, state_dbg);
    end
    req = 4'b1000;
    adv(1);
    req = 4'b0000;
    reset = 1'b0;
    adv(5);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_dominates_req: got grant=%b busy=%b st=%0d expected 0000/0/IDLE",
               grant, busy, state_dbg);
    end
  endtask

  task automatic test_single_jump;
    start_req(4'b0001);
    checks++;
    if (grant !== 4'b0001 || active_id !== 2'd0 || busy !== 1'b1 || state_dbg !== S_PLAY) begin
      errors++;
      $display("FAIL jump_grant: got grant=%b id=%0d busy=%b st=%0d expected 0001/0/1/PLAY",
               grant, active_id, busy, state_dbg);
    end
    adv(1);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL jump_grant_pulse: got %b expected 0000", grant);
    end
    goto_rel(147);
    checks++;
    if (speaker !== 1'b0) begin
      errors++;
      $display("FAIL jump_spk_before_rise: got %b expected 0", speaker);
    end
    adv(1);
    checks++;
    if (speaker !== 1'b1) begin
      errors++;
      $display("FAIL jump_spk_rise: got %b expected 1", speaker);
    end
    goto_rel(295);
    checks++;
    if (speaker !== 1'b1) begin
      errors++;
      $display("FAIL jump_spk_high: got %b expected 1", speaker);
    end
    adv(1);
    checks++;
    if (speaker !== 1'b0) begin
      errors++;
      $display("FAIL jump_spk_fall: got %b expected 0", speaker);
    end
    goto_rel(1499);
    checks++;
    if (state_dbg !== S_PLAY) begin
      errors++;
      $display("FAIL jump_still_play: got st=%0d expected PLAY", state_dbg);
    end
    adv(1);
    checks++;
    if (state_dbg !== S_GAP || speaker !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL jump_end: got st=%0d spk=%b busy=%b expected GAP/0/1", state_dbg, speaker, busy);
    end
    goto_rel(1519);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL jump_gap_busy: got %b expected 1", busy);
    end
    adv(1);
    checks++;
    if (busy !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL jump_busy_fall: got busy=%b st=%0d expected 0/IDLE", busy, state_dbg);
    end
    adv(3);
  endtask

  task automatic test_simultaneous;
    start_req(4'b1010);
    checks++;
    if (grant !== 4'b1000 || active_id !== 2'd3) begin
      errors++;
      $display("FAIL simul_hit_grant: got grant=%b id=%0d expected 1000/3", grant, active_id);
    end
    goto_rel(92);
    checks++;
    if (speaker !== 1'b0) begin
      errors++;
      $display("FAIL hit_spk_before_rise: got %b expected 0", speaker);
    end
    adv(1);
    checks++;
    if (speaker !== 1'b1) begin
      errors++;
      $display("FAIL hit_spk_rise: got %b expected 1", speaker);
    end
    goto_rel(1999);
    checks++;
    if (state_dbg !== S_PLAY) begin
      errors++;
      $display("FAIL hit_still_play: got st=%0d expected PLAY", state_dbg);
    end
    adv(1);
    checks++;
    if (state_dbg !== S_GAP) begin
      errors++;
      $display("FAIL hit_end: got st=%0d expected GAP", state_dbg);
    end
    goto_rel(2020);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL simul_gap_exit: got grant=%b busy=%b st=%0d expected 0000/0/IDLE",
               grant, busy, state_dbg);
    end
    adv(1);
    checks++;
    if (grant !== 4'b0010 || active_id !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_punch_grant: got grant=%b id=%0d busy=%b expected 0010/1/1",
               grant, active_id, busy);
    end
    goto_rel(3020);
    checks++;
    if (state_dbg !== S_PLAY) begin
      errors++;
      $display("FAIL punch_still_play: got st=%0d expected PLAY", state_dbg);
    end
    adv(1);
    checks++;
    if (state_dbg !== S_GAP) begin
      errors++;
      $display("FAIL punch_end: got st=%0d expected GAP", state_dbg);
    end
    goto_rel(3045);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL simul_drained: got grant=%b busy=%b st=%0d expected 0000/0/IDLE",
               grant, busy, state_dbg);
    end
  endtask

  task automatic test_preempt;
    int gr_seen;
    int busy_low;
    gr_seen = 0;
    busy_low = 0;
    start_req(4'b0001);
    goto_rel(500);
    req = 4'b1000;
    adv(1);
    req = 4'b0000;
    checks++;
    if (grant !== 4'b0000 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL preempt_latch: got grant=%b id=%0d expected 0000/0", grant, active_id);
    end
    adv(1);
    checks++;
    if (grant !== 4'b1000 || active_id !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL preempt_grant: got grant=%b id=%0d busy=%b expected 1000/3/1",
               grant, active_id, busy);
    end
    for (int k = 503; k <= 2560; k++) begin
      adv(1);
      if (grant !== 4'b0000) gr_seen++;
      if (k <= 2521 && busy !== 1'b1) busy_low++;
      if (k == 2522) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL preempt_busy_fall: got %b expected 0", busy);
        end
      end
    end
    checks++;
    if (gr_seen !== 0) begin
      errors++;
      $display("FAIL preempt_no_regrant: got %0d grants expected 0", gr_seen);
    end
    checks++;
    if (busy_low !== 0) begin
      errors++;
      $display("FAIL preempt_busy_held: got %0d low cycles expected 0", busy_low);
    end
  endtask

  task automatic test_retrigger;
    start_req(4'b0001);
    goto_rel(1000);
    req = 4'b0001;
    adv(1);
    req = 4'b0000;
    checks++;
    if (grant !== 4'b0001 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL retrig_grant: got grant=%b id=%0d expected 0001/0", grant, active_id);
    end
    adv(1);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL retrig_grant_pulse: got %b expected 0000", grant);
    end
    goto_rel(1035);
    checks++;
    if (speaker !== 1'b0) begin
      errors++;
      $display("FAIL retrig_phase_low: got %b expected 0", speaker);
    end
    adv(1);
    checks++;
    if (speaker !== 1'b1) begin
      errors++;
      $display("FAIL retrig_phase_rise: got %b expected 1", speaker);
    end
    goto_rel(2500);
    checks++;
    if (state_dbg !== S_PLAY) begin
      errors++;
      $display("FAIL retrig_still_play: got st=%0d expected PLAY", state_dbg);
    end
    adv(1);
    checks++;
    if (state_dbg !== S_GAP || speaker !== 1'b0) begin
      errors++;
      $display("FAIL retrig_end: got st=%0d spk=%b expected GAP/0", state_dbg, speaker);
    end
    goto_rel(2525);
    checks++;
    if (state_dbg !== S_IDLE || grant !== 4'b0000) begin
      errors++;
      $display("FAIL retrig_no_pend: got st=%0d grant=%b expected IDLE/0000", state_dbg, grant);
    end
  endtask

  task automatic test_music;
    logic [7:0] pat;
    logic       prev;
    pat = 8'b1011_0010;
    prev = 1'b0;
    mute = 1'b0;
    for (int i = 0; i < 8; i++) begin
      music_in = pat[i];
      checks++;
      if (speaker !== prev) begin
        errors++;
        $display("FAIL music_delay[%0d]: got %b expected %b", i, speaker, prev);
      end
      adv(1);
      checks++;
      if (speaker !== pat[i]) begin
        errors++;
        $display("FAIL music_follow[%0d]: got %b expected %b", i, speaker, pat[i]);
      end
      prev = pat[i];
    end
    mute = 1'b1;
    music_in = 1'b1;
    adv(4);
    checks++;
    if (speaker !== 1'b0) begin
      errors++;
      $display("FAIL music_mute: got %b expected 0", speaker);
    end
    start_req(4'b0001);
    checks++;
    if (speaker !== 1'b0) begin
      errors++;
      $display("FAIL mute_play_start: got %b expected 0", speaker);
    end
    goto_rel(148);
    checks++;
    if (speaker !== 1'b1) begin
      errors++;
      $display("FAIL mute_play_tone: got %b expected 1", speaker);
    end
    goto_rel(1525);
    checks++;
    if (busy !== 1'b0 || speaker !== 1'b0) begin
      errors++;
      $display("FAIL mute_idle_after: got busy=%b spk=%b expected 0/0", busy, speaker);
    end
    mute = 1'b0;
    music_in = 1'b0;
    adv(2);
  endtask

  task automatic test_reset_mid;
    int gr_seen;
    gr_seen = 0;
    start_req(4'b0100);
    goto_rel(10);
    req = 4'b0010;
    adv(1);
    req = 4'b0000;
    goto_rel(50);
    checks++;
    if (active_id !== 2'd2 || state_dbg !== S_PLAY) begin
      errors++;
      $display("FAIL kick_playing: got id=%0d st=%0d expected 2/PLAY", active_id, state_dbg);
    end
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
    checks++;
    if ({speaker, busy, active_id, grant, state_dbg} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got spk=%b busy=%b id=%0d grant=%b st=%0d expected all 0",
               speaker, busy, active_id, grant, state_dbg);
    end
    for (int k = 0; k < 200; k++) begin
      adv(1);
      if (grant !== 4'b0000 || busy !== 1'b0) gr_seen++;
    end
    checks++;
    if (gr_seen !== 0) begin
      errors++;
      $display("FAIL reset_drops_pend: got %0d active cycles expected 0", gr_seen);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rel = 0;
    reset = 1'b1;
    req = 4'b0000;
    music_in = 1'b0;
    mute = 1'b0;
    test_reset;
    test_single_jump;
    test_simultaneous;
    test_preempt;
    test_retrigger;
    test_music;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
